// File: rtl/sram_bank_arbiter.sv
// Multi-requester, multi-bank SRAM arbiter: independent round-robin grant per bank,
// single-cycle read return routed by a registered per-bank tag.
module sram_bank_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 256,
    parameter int BADDR_W   = ADDR_W - 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0]     rsp_rdata,
    output logic [NUM_BANKS-1:0]          bank_en,
    output logic [NUM_BANKS-1:0]          bank_we,
    output logic [NUM_BANKS*BADDR_W-1:0]  bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata
);

    localparam int BSEL_W = 2;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]          rr_ptr_q  [NUM_BANKS];
    logic [PTR_W-1:0]          rr_ptr_d  [NUM_BANKS];
    logic [NUM_BANKS-1:0]      tag_vld_q;
    logic [NUM_BANKS-1:0]      tag_vld_d;
    logic [PTR_W-1:0]          tag_id_q  [NUM_BANKS];
    logic [PTR_W-1:0]          tag_id_d  [NUM_BANKS];
    logic [NUM_REQ*DATA_W-1:0] rdata_q;

    // Round-robin search per bank, starting at rr_ptr; first matching requester wins.
    always_comb begin
        req_ready  = '0;
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        tag_vld_d  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rr_ptr_d[b] = rr_ptr_q[b];
            tag_id_d[b] = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (!bank_en[b] && r == ((int'(rr_ptr_q[b]) + k) % NUM_REQ) && req_valid[r]
                        && req_addr[r*ADDR_W +: BSEL_W] == BSEL_W'(b)) begin
                        req_ready[r]                       = 1'b1;
                        bank_en[b]                         = 1'b1;
                        bank_we[b]                         = req_we[r];
                        bank_addr[b*BADDR_W +: BADDR_W]    = req_addr[r*ADDR_W + BSEL_W +: BADDR_W];
                        bank_wdata[b*DATA_W +: DATA_W]     = req_wdata[r*DATA_W +: DATA_W];
                        tag_vld_d[b]                       = !req_we[r];
                        tag_id_d[b]                        = PTR_W'(r);
                        rr_ptr_d[b]                        = (r + 1 >= NUM_REQ) ? '0 : PTR_W'(r + 1);
                    end
                end
            end
        end
    end

    // At most one tag per requester is live at a time, since a requester holds one address.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = rdata_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (tag_vld_q[b] && tag_id_q[b] == PTR_W'(r)) begin
                    rsp_valid[r]                   = 1'b1;
                    rsp_rdata[r*DATA_W +: DATA_W]  = bank_rdata[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            rdata_q   <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= '0;
                tag_id_q[b] <= '0;
            end
        end else begin
            tag_vld_q <= tag_vld_d;
            rdata_q   <= rsp_rdata;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
                tag_id_q[b] <= tag_id_d[b];
            end
        end
    end

endmodule
